beq_sweep: RTL and testbench

Sequential truth-table engine for N-input Boolean functions. A loadable 2^N-entry truth table defines the function. On `start`, the block steps its input vector `x` through every combination 0 to 2^N-1 and holds each vector for HOLD cycles. It drives the function output `z`, captures every output into `result`, and counts the minterms that evaluate to 1. Together this gives self-checking, exhaustive evaluation of the combinational equation blocks in the lab set.

---
 rtl/beq_sweep.sv | 97 +++++++++
 tb/tb_beq_sweep.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/beq_sweep.sv
// Sequential truth-table engine: sweeps an N-input vector through all 2^N
// combinations, drives the table value, captures every output and counts ones.
module beq_sweep #(
  parameter int N    = 4,
  parameter int HOLD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tt_load,
  input  logic [2**N-1:0]   tt_in,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      x,
  output logic              z,
  output logic [2**N-1:0]   result,
  output logic [N:0]        ones
);

  localparam int              TT_W     = 2**N;
  localparam int              HC_W     = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HC_W-1:0] HC_LAST  = HC_W'(HOLD - 1);
  localparam logic [N-1:0]    X_LAST   = '1;
  localparam logic [N:0]      ONES_MAX = (N+1)'(TT_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]      r_state;
  logic [TT_W-1:0] r_tt;
  logic [TT_W-1:0] r_result;
  logic [N-1:0]    r_x;
  logic [HC_W-1:0] r_hold;
  logic [N:0]      r_ones;
  logic            w_bit;
  logic            w_cap;

  // Count of ones is bounded by the table size, so it saturates instead of wrapping.
  function automatic logic [N:0] sat_add(input logic [N:0] a, input logic b);
    if (b && (a != ONES_MAX))
      return a + (N+1)'(1);
    return a;
  endfunction

  assign w_bit = r_tt[r_x];
  assign w_cap = (r_state == S_SWEEP) && (r_hold == HC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_tt     <= '0;
      r_result <= '0;
      r_x      <= '0;
      r_hold   <= '0;
      r_ones   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (tt_load)
            r_tt <= tt_in;
          // A load in the same cycle is visible to the sweep: first capture is a cycle later.
          if (start) begin
            r_state  <= S_SWEEP;
            r_x      <= '0;
            r_hold   <= '0;
            r_result <= '0;
            r_ones   <= '0;
          end
        end
        S_SWEEP: begin
          if (w_cap) begin
            r_result[r_x] <= w_bit;
            r_ones        <= sat_add(r_ones, w_bit);
            r_hold        <= '0;
            if (r_x == X_LAST)
              r_state <= S_DONE;
            else
              r_x <= r_x + N'(1);
          end else begin
            r_hold <= r_hold + HC_W'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state == S_SWEEP);
  assign done   = (r_state == S_DONE);
  assign x      = r_x;
  assign z      = w_bit;
  assign result = r_result;
  assign ones   = r_ones;

endmodule

// File: tb/tb_beq_sweep.sv
// Directed bench for beq_sweep: one HOLD=1 instance and one HOLD=3 instance.
module tb_beq_sweep;

  logic        clk = 1'b0;
  logic        rst;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;

  logic        tt_load, start;
  logic [15:0] tt_in;
  logic        busy, done, z;
  logic [3:0]  x;
  logic [15:0] result;
  logic [4:0]  ones;

  logic        h_tt_load, h_start;
  logic [15:0] h_tt_in;
  logic        h_busy, h_done, h_z;
  logic [3:0]  h_x;
  logic [15:0] h_result;
  logic [4:0]  h_ones;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  beq_sweep #(.N(4), .HOLD(1)) dut (
    .clk(clk), .rst(rst), .tt_load(tt_load), .tt_in(tt_in), .start(start),
    .busy(busy), .done(done), .x(x), .z(z), .result(result), .ones(ones)
  );

  beq_sweep #(.N(4), .HOLD(3)) dut3 (
    .clk(clk), .rst(rst), .tt_load(h_tt_load), .tt_in(h_tt_in), .start(h_start),
    .busy(h_busy), .done(h_done), .x(h_x), .z(h_z), .result(h_result), .ones(h_ones)
  );

  task automatic test_reset();
    rst = 1'b1; tt_load = 1'b0; start = 1'b0; tt_in = 16'h0;
    h_tt_load = 1'b0; h_start = 1'b0; h_tt_in = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busy, done, x, z, result, ones} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b x=%0d z=%b result=%h ones=%0d, want all zero",
               busy, done, x, z, result, ones);
    end
    n_tests++;
    if ({h_busy, h_done, h_x, h_z, h_result, h_ones} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_state_h3: busy=%b done=%b x=%0d result=%h ones=%0d, want all zero",
               h_busy, h_done, h_x, h_result, h_ones);
    end
  endtask

  task automatic load_table(input logic [15:0] v);
    tt_load = 1'b1; tt_in = v;
    @(negedge clk);
    tt_load = 1'b0; tt_in = 16'h0;
  endtask

  // Starts a sweep (optionally with a same-cycle load) and checks every vector,
  // the done pulse and the final capture. Returns at the first IDLE cycle.
  task automatic run_sweep(input string nm, input logic with_load, input logic [15:0] tbl,
                           input logic [4:0] exp_ones, output int start_cyc);
    int bad;
    start = 1'b1;
    if (with_load) begin tt_load = 1'b1; tt_in = tbl; end
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0; tt_load = 1'b0; tt_in = 16'h0;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (x !== k[3:0] || z !== tbl[k] || busy !== 1'b1 || done !== 1'b0) begin
        if (bad == 0)
          $display("FAIL %s_vec%0d: x=%0d z=%b busy=%b done=%b, want x=%0d z=%b busy=1 done=0",
                   nm, k, x, z, busy, done, k, tbl[k]);
        bad++;
      end
      @(negedge clk);
    end
    n_tests++;
    if (bad != 0) n_fail++;
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: done=%b busy=%b, want done=1 busy=0", nm, done, busy);
    end
    n_tests++;
    if (result !== tbl || ones !== exp_ones) begin
      n_fail++;
      $display("FAIL %s_result: result=%h ones=%0d, want result=%h ones=%0d",
               nm, result, ones, tbl, exp_ones);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || x !== 4'hF || result !== tbl || ones !== exp_ones) begin
      n_fail++;
      $display("FAIL %s_after: done=%b busy=%b x=%0d result=%h ones=%0d, want 0 0 15 %h %0d",
               nm, done, busy, x, result, ones, tbl, exp_ones);
    end
  endtask

  task automatic test_basic();
    int sc;
    load_table(16'hA5C3);
    run_sweep("basic", 1'b0, 16'hA5C3, 5'd8, sc);
  endtask

  task automatic test_extremes();
    int sc;
    load_table(16'h0000);
    run_sweep("zeros", 1'b0, 16'h0000, 5'd0, sc);
    load_table(16'hFFFF);
    run_sweep("ones", 1'b0, 16'hFFFF, 5'd16, sc);
  endtask

  task automatic test_hold();
    int busy_cnt, bad;
    h_tt_load = 1'b1; h_tt_in = 16'h8001;
    @(negedge clk);
    h_tt_load = 1'b0; h_start = 1'b1;
    @(negedge clk);
    h_start = 1'b0;
    busy_cnt = 0; bad = 0;
    for (int k = 0; k < 16; k++) begin
      for (int h = 0; h < 3; h++) begin
        if (h_busy === 1'b1) busy_cnt++;
        if (h_x !== k[3:0] || h_z !== (k == 0 || k == 15) || h_done !== 1'b0) begin
          if (bad == 0)
            $display("FAIL hold_vec%0d_%0d: x=%0d z=%b done=%b, want x=%0d", k, h, h_x, h_z, h_done, k);
          bad++;
        end
        @(negedge clk);
      end
    end
    n_tests++;
    if (bad != 0) n_fail++;
    n_tests++;
    if (busy_cnt != 48) begin
      n_fail++;
      $display("FAIL hold_busy_cycles: got %0d, want 48", busy_cnt);
    end
    n_tests++;
    if (h_done !== 1'b1 || h_busy !== 1'b0 || h_ones !== 5'd2 || h_result !== 16'h8001) begin
      n_fail++;
      $display("FAIL hold_done: done=%b busy=%b ones=%0d result=%h, want 1 0 2 8001",
               h_done, h_busy, h_ones, h_result);
    end
    @(negedge clk);
    n_tests++;
    if (h_done !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_done_width: done=%b, want 0", h_done);
    end
  endtask

  task automatic test_ignored();
    int sc, bad;
    load_table(16'hA5C3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 5) begin tt_load = 1'b1; tt_in = 16'hFFFF; start = 1'b1; end
      else begin tt_load = 1'b0; tt_in = 16'h0; start = 1'b0; end
      if (x !== k[3:0] || z !== tbl_a5c3(k) || busy !== 1'b1) begin
        if (bad == 0) $display("FAIL ignored_vec%0d: x=%0d z=%b busy=%b", k, x, z, busy);
        bad++;
      end
      @(negedge clk);
    end
    tt_load = 1'b0; start = 1'b0;
    n_tests++;
    if (bad != 0) n_fail++;
    n_tests++;
    if (done !== 1'b1 || result !== 16'hA5C3 || ones !== 5'd8) begin
      n_fail++;
      $display("FAIL ignored_result: done=%b result=%h ones=%0d, want 1 a5c3 8", done, result, ones);
    end
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ignored_no_second_sweep: %0d busy/done cycles seen, want 0", bad);
    end
    run_sweep("ignored_reuse", 1'b0, 16'hA5C3, 5'd8, sc);
  endtask

  function automatic logic tbl_a5c3(input int k);
    logic [15:0] t;
    t = 16'hA5C3;
    return t[k];
  endfunction

  task automatic test_reset_mid();
    int guard, dcnt;
    load_table(16'hA5C3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (x !== 4'd7 && guard < 20) begin @(negedge clk); guard++; end
    n_tests++;
    if (x !== 4'd7) begin
      n_fail++;
      $display("FAIL midreset_reach_x7: x=%0d, want 7", x);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || x !== 4'd0 || result !== 16'h0 || ones !== 5'd0 || z !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: busy=%b done=%b x=%0d result=%h ones=%0d z=%b, want all zero",
               busy, done, x, result, ones, z);
    end
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) dcnt++;
    end
    n_tests++;
    if (dcnt != 0) begin
      n_fail++;
      $display("FAIL midreset_no_done: %0d busy/done cycles seen, want 0", dcnt);
    end
  endtask

  task automatic test_back_to_back();
    int sc1, sc2;
    run_sweep("loadstart", 1'b1, 16'h00FF, 5'd8, sc1);
    run_sweep("b2b", 1'b0, 16'h00FF, 5'd8, sc2);
    n_tests++;
    if (sc2 - sc1 != 18) begin
      n_fail++;
      $display("FAIL b2b_period: got %0d cycles, want 18", sc2 - sc1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_hold();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
